// File: rtl/td4_register_bank.sv
// td4_register_bank: write-back demux into A/B/OUT/PC, plus the PC incrementer and the carry flag
//   clk_i      system clock, rising edge
//   rst_ni     asynchronous active-low reset
//   en_i       step enable; low holds every register and clears out_stb_o
//   we_i       write enable for d_i
//   dest_i     destination: 0=A 1=B 2=OUT 3=PC
//   d_i        write-back data
//   cin_i      ALU carry-out, captured into cf_o on every enabled edge
//   qa_o/qb_o  registers A and B
//   qout_o     output-port register
//   qpc_o      program counter
//   cf_o       carry flag
//   out_stb_o  one-cycle pulse after each OUT write
module td4_register_bank #(
   parameter int BIT_WIDTH = 4
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 en_i,
   input  logic                 we_i,
   input  logic [1:0]           dest_i,
   input  logic [BIT_WIDTH-1:0] d_i,
   input  logic                 cin_i,
   output logic [BIT_WIDTH-1:0] qa_o,
   output logic [BIT_WIDTH-1:0] qb_o,
   output logic [BIT_WIDTH-1:0] qout_o,
   output logic [BIT_WIDTH-1:0] qpc_o,
   output logic                 cf_o,
   output logic                 out_stb_o
);
   logic [BIT_WIDTH-1:0] qa_q, qa_d, qb_q, qb_d, qout_q, qout_d, qpc_q, qpc_d;
   logic                 cf_q, cf_d, stb_q, stb_d;
   logic                 wr;
   always_comb begin
      wr     = en_i & we_i;
      qa_d   = (wr && dest_i == 2'd0) ? d_i : qa_q;
      qb_d   = (wr && dest_i == 2'd1) ? d_i : qb_q;
      qout_d = (wr && dest_i == 2'd2) ? d_i : qout_q;
      // a jump load wins over the increment; the increment wraps naturally
      qpc_d  = !en_i ? qpc_q : (wr && dest_i == 2'd3) ? d_i : qpc_q + 1'b1;
      cf_d   = en_i ? cin_i : cf_q;
      stb_d  = wr && dest_i == 2'd2;
   end
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         qa_q   <= '0;
         qb_q   <= '0;
         qout_q <= '0;
         qpc_q  <= '0;
         cf_q   <= 1'b0;
         stb_q  <= 1'b0;
      end else begin
         qa_q   <= qa_d;
         qb_q   <= qb_d;
         qout_q <= qout_d;
         qpc_q  <= qpc_d;
         cf_q   <= cf_d;
         stb_q  <= stb_d;
      end
   end
   assign qa_o      = qa_q;
   assign qb_o      = qb_q;
   assign qout_o    = qout_q;
   assign qpc_o     = qpc_q;
   assign cf_o      = cf_q;
   assign out_stb_o = stb_q;
endmodule

// File: tb/tb_td4_register_bank.sv
// tb_td4_register_bank: directed self-checking bench for td4_register_bank
module tb_td4_register_bank;
   logic       clk = 1'b0, rst_n = 1'b0, en = 1'b0, we = 1'b0, cin = 1'b0;
   logic [1:0] dest = 2'd0;
   logic [3:0] d = 4'd0;
   logic [3:0] qa, qb, qout, qpc;
   logic       cf, stb;
   int         passed = 0, total = 0;

   td4_register_bank #(.BIT_WIDTH(4)) dut (
      .clk_i(clk), .rst_ni(rst_n), .en_i(en), .we_i(we), .dest_i(dest), .d_i(d),
      .cin_i(cin), .qa_o(qa), .qb_o(qb), .qout_o(qout), .qpc_o(qpc), .cf_o(cf),
      .out_stb_o(stb)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      total++;
      assert (got === exp) passed++;
      else $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic all_zero(input string tag);
      chk({tag, "_qa"}, int'(qa), 0);
      chk({tag, "_qb"}, int'(qb), 0);
      chk({tag, "_qout"}, int'(qout), 0);
      chk({tag, "_qpc"}, int'(qpc), 0);
      chk({tag, "_cf"}, int'(cf), 0);
      chk({tag, "_stb"}, int'(stb), 0);
   endtask

   task automatic drive(input logic e, input logic w, input logic [1:0] ds, input logic [3:0] dv, input logic c);
      en = e; we = w; dest = ds; d = dv; cin = c;
   endtask

   initial begin
      #2 all_zero("reset");
      #10 rst_n = 1'b1;
      // writes
      drive(1, 1, 0, 4'h3, 0); step();
      chk("wr_a_qa", qa, 3); chk("wr_a_qpc", qpc, 1); chk("wr_a_stb", stb, 0); chk("wr_a_qb", qb, 0);
      drive(1, 1, 1, 4'hA, 0); step();
      chk("wr_b_qb", qb, 10); chk("wr_b_qa", qa, 3); chk("wr_b_qpc", qpc, 2); chk("wr_b_stb", stb, 0);
      drive(1, 1, 2, 4'h6, 0); step();
      chk("wr_out_qout", qout, 6); chk("wr_out_stb", stb, 1); chk("wr_out_qpc", qpc, 3);
      chk("wr_out_qa", qa, 3); chk("wr_out_qb", qb, 10);
      drive(1, 0, 2, 4'hF, 0); step();
      chk("idle_stb", stb, 0); chk("idle_qout", qout, 6); chk("idle_qpc", qpc, 4);
      // jump and wrap
      drive(1, 1, 3, 4'd14, 0); step();
      chk("jump_qpc", qpc, 14); chk("jump_qa", qa, 3);
      drive(1, 0, 3, 4'd0, 0); step();
      chk("inc15_qpc", qpc, 15);
      step();
      chk("wrap_qpc", qpc, 0);
      drive(1, 1, 3, 4'd0, 0); step();
      chk("selfloop_qpc", qpc, 0);
      // halt
      drive(1, 1, 0, 4'd7, 0); step();
      chk("pre_halt_qa", qa, 7);
      drive(1, 1, 3, 4'd4, 0); step();
      chk("pre_halt_qpc", qpc, 4);
      drive(0, 1, 0, 4'd1, 1);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("halt_qa", qa, 7); chk("halt_qpc", qpc, 4); chk("halt_cf", cf, 0); chk("halt_stb", stb, 0);
      end
      // carry
      drive(1, 0, 0, 4'd0, 1); step();
      chk("cf1", cf, 1); chk("cf1_qpc", qpc, 5);
      cin = 0; step();
      chk("cf0", cf, 0); chk("cf0_qpc", qpc, 6);
      cin = 1; step();
      chk("cf1b", cf, 1); chk("cf1b_qpc", qpc, 7); chk("cf_qa", qa, 7);
      // back-to-back OUT
      drive(1, 1, 2, 4'd9, 0); step();
      chk("b2b1_stb", stb, 1); chk("b2b1_qout", qout, 9); chk("b2b1_cf", cf, 0); chk("b2b1_qpc", qpc, 8);
      step();
      chk("b2b2_stb", stb, 1); chk("b2b2_qout", qout, 9);
      d = 4'd2; step();
      chk("b2b3_stb", stb, 1); chk("b2b3_qout", qout, 2); chk("b2b3_qpc", qpc, 10);
      we = 0; step();
      chk("b2b_end_stb", stb, 0); chk("b2b_end_qout", qout, 2); chk("b2b_end_qpc", qpc, 11);
      // async reset mid-operation
      drive(1, 1, 0, 4'd5, 0); step();
      drive(1, 1, 3, 4'd9, 1); step();
      chk("pre_rst_qa", qa, 5); chk("pre_rst_qpc", qpc, 9); chk("pre_rst_cf", cf, 1);
      #2 rst_n = 1'b0;
      #1 all_zero("async_rst");
      step();
      all_zero("rst_hold");
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/td4_register_bank.md
Name: td4_register_bank

Overview:
- Write-side counterpart of the 4:1 operand selector. Demultiplexes one write-back word into one of four architectural registers: A, B, OUT port and PC.
- Also owns the PC increment counter and the carry flag register.
- Sits after the ALU. Its register outputs feed the selector inputs, the output port and the program ROM address.

Parameters:
- bitWidth, 4, width of every data register and of the PC.

Ports:
- CLK  input  1  system clock; all state changes on the rising edge.
- nRST  input  1  asynchronous active-low reset.
- EN  input  1  step enable; when 0 all state holds (single-step / halt).
- WE  input  1  write enable for the write-back word.
- DEST  input  2  destination select: 0=A, 1=B, 2=OUT, 3=PC.
- D  input  bitWidth  write-back data from the ALU.
- CIN  input  1  ALU carry-out for the current instruction.
- QA  output  bitWidth  register A contents.
- QB  output  bitWidth  register B contents.
- QOUT  output  bitWidth  output-port register contents.
- QPC  output  bitWidth  program counter.
- CF  output  1  carry flag, registered.
- OUT_STB  output  1  one-cycle pulse: output port updated on the previous edge.

Behaviour:
- Clock and reset: one clock, CLK. nRST is asynchronous and active-low.
- Reset (nRST=0, asynchronous, no clock needed):
  - QA, QB, QOUT, QPC = 0.
  - CF = 0, OUT_STB = 0.
  - Reset holds while nRST is low.
  - The first update is on the first rising CLK edge with nRST=1 and EN=1.
- Reset asserted mid-operation clears all state immediately, regardless of EN or WE.
- All updates are registered, with one-cycle latency. The outputs are the register values directly; there is no combinational path from inputs to outputs.
- Rising edge with EN=0: every register holds and OUT_STB <= 0.
- Rising edge with EN=1:
  - Exactly one destination is written, and only when WE=1:
    - DEST=0 -> QA <= D.
    - DEST=1 -> QB <= D.
    - DEST=2 -> QOUT <= D.
    - DEST=3 -> QPC <= D.
  - Non-selected registers hold.
  - WE=0: no data register is written; DEST and D are ignored.
  - PC:
    - If WE=1 and DEST=3, QPC <= D (jump). The load takes priority over the increment; there is no extra increment that cycle.
    - Otherwise QPC <= QPC + 1, modulo 2^bitWidth. For bitWidth=4 it wraps 15 -> 0 with no flag or stall.
  - CF <= CIN on every enabled edge, independent of WE/DEST.
  - OUT_STB <= 1 iff WE=1 and DEST=2. Otherwise OUT_STB <= 0.
    - The pulse is exactly one cycle even for back-to-back OUT writes: it stays high for consecutive cycles, one per write.
    - Writing the same value to OUT still pulses.
- Simultaneous events:
  - EN=0 with WE=1 is a no-op.
  - A jump to the current PC value (D == QPC) holds the PC, i.e. a self-loop.
- D is bitWidth wide. Values of DEST outside 0..3 are impossible by width. No X-propagation paths; every case is defined.
- Internal state is only the five registers plus OUT_STB; no FSM beyond the PC counter.

Test Plan:
- Reset: drive nRST=0 asynchronously mid-cycle with prior nonzero state (QA=5, QPC=9, CF=1) -> all outputs 0 before the next CLK edge. They stay 0 while nRST=0.
- Writes: EN=1, WE=1; DEST=0 D=3, then DEST=1 D=0xA, then DEST=2 D=0x6.
  - Required: QA=3, QB=0xA, QOUT=6, in order.
  - QPC goes 0->1->2->3.
  - OUT_STB high only in the cycle after the third edge.
  - Non-selected registers unchanged.
- Jump and wrap:
  - WE=1 DEST=3 D=14 -> QPC=14 (no +1).
  - Then WE=0 for 2 edges -> QPC=15, then 0.
  - Then DEST=3 D=0 with QPC=0 -> QPC stays 0.
- Halt: with QA=7 and QPC=4, set EN=0 and drive WE=1 DEST=0 D=1, CIN=1 for 3 edges -> QA=7, QPC=4, CF unchanged, OUT_STB=0.
- Carry: EN=1 with CIN sequence 1,0,1 and WE=0 -> CF follows 1,0,1 one edge later. The PC increments each edge.
- Back-to-back OUT: WE=1 DEST=2 with D=9,9,2 on three edges -> OUT_STB high for three consecutive cycles, QOUT=9,9,2. The cycle after the third write with WE=0 -> OUT_STB=0.
